// File: rtl/fml_arb_pkg.sv
// fml_arb_pkg: shared constants, state encoding and round-robin picker for fml_arb
package fml_arb_pkg;
    localparam int FML_NMASTERS = 4;
    localparam int FML_BURST = 4;
    typedef enum logic {IDLE, GRANT} state_t;
    typedef logic [$clog2(FML_NMASTERS)-1:0] midx_t;
    typedef logic [$clog2(FML_BURST+1)-1:0] wcnt_t;
    // Nearest requester after base wins; base itself is tried last.
    function automatic midx_t rr_pick(input logic [FML_NMASTERS-1:0] req, input midx_t base);
        midx_t c;
        rr_pick = base;
        for (int i = FML_NMASTERS; i >= 1; i--) begin
            c = base + midx_t'(i);
            if (req[c]) rr_pick = c;
        end
    endfunction
endpackage

// File: rtl/fml_arb_wdata.sv
// fml_arb_wdata: steers write-burst data and masks from the acknowledged writer to the controller
// Ports: sys_clk, sys_rst (sync, active-high); load = write eack, owner = granted master;
// di/sel = all masters' write data/masks; s_di/s_sel = data/mask to the controller.
module fml_arb_wdata import fml_arb_pkg::*; (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        load,
    input  midx_t       owner,
    input  logic [63:0] di [FML_NMASTERS],
    input  logic [7:0]  sel [FML_NMASTERS],
    output logic [63:0] s_di,
    output logic [7:0]  s_sel
);
    wcnt_t wcnt;
    midx_t wown;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wcnt <= '0;
            wown <= '0;
        end else if (load) begin
            wcnt <= wcnt_t'(FML_BURST);
            wown <= owner;
        end else if (wcnt != '0) begin
            wcnt <= wcnt - wcnt_t'(1);
        end
    end
    assign s_di  = wcnt != '0 ? di[wown]  : '0;
    assign s_sel = wcnt != '0 ? sel[wown] : '0;
    // A new write may only be acknowledged on the last beat of the running burst.
    assert property (@(posedge sys_clk) disable iff (sys_rst) !(load && wcnt > wcnt_t'(1)));
endmodule

// File: rtl/fml_arb.sv
// fml_arb: four-master round-robin arbiter for the single FML 4x64 port of hpdmc
// Ports: sys_clk, sys_rst (sync, active-high); mN_adr/stb/we/sel/di in and mN_eack/do out
// per master N = 0..3; s_adr/stb/we/sel/di out and s_eack/do in toward the controller.
// FML_ARB_PRIO_EN: when defined, master 0 wins every arbitration point at which it requests.
module fml_arb import fml_arb_pkg::*; #(
    parameter int sdram_depth = 26
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [sdram_depth-1:0] m0_adr,
    input  logic                   m0_stb,
    input  logic                   m0_we,
    output logic                   m0_eack,
    input  logic [7:0]             m0_sel,
    input  logic [63:0]            m0_di,
    output logic [63:0]            m0_do,
    input  logic [sdram_depth-1:0] m1_adr,
    input  logic                   m1_stb,
    input  logic                   m1_we,
    output logic                   m1_eack,
    input  logic [7:0]             m1_sel,
    input  logic [63:0]            m1_di,
    output logic [63:0]            m1_do,
    input  logic [sdram_depth-1:0] m2_adr,
    input  logic                   m2_stb,
    input  logic                   m2_we,
    output logic                   m2_eack,
    input  logic [7:0]             m2_sel,
    input  logic [63:0]            m2_di,
    output logic [63:0]            m2_do,
    input  logic [sdram_depth-1:0] m3_adr,
    input  logic                   m3_stb,
    input  logic                   m3_we,
    output logic                   m3_eack,
    input  logic [7:0]             m3_sel,
    input  logic [63:0]            m3_di,
    output logic [63:0]            m3_do,
    output logic [sdram_depth-1:0] s_adr,
    output logic                   s_stb,
    output logic                   s_we,
    input  logic                   s_eack,
    output logic [7:0]             s_sel,
    output logic [63:0]            s_di,
    input  logic [63:0]            s_do
);
    logic [sdram_depth-1:0] adr [FML_NMASTERS];
    logic [7:0] sel [FML_NMASTERS];
    logic [63:0] di [FML_NMASTERS];
    logic [FML_NMASTERS-1:0] stb, we, req;
    state_t state;
    midx_t grant, last_grant, base, pick;
    logic in_grant, ack, rearb;
    assign adr = '{m0_adr, m1_adr, m2_adr, m3_adr};
    assign sel = '{m0_sel, m1_sel, m2_sel, m3_sel};
    assign di  = '{m0_di, m1_di, m2_di, m3_di};
    assign stb = {m3_stb, m2_stb, m1_stb, m0_stb};
    assign we  = {m3_we, m2_we, m1_we, m0_we};
    assign in_grant = state == GRANT;
    assign ack = in_grant & s_eack;
    // On eack the served master is masked out so a pending peer takes over with no bubble.
    assign req  = ack ? stb & ~(FML_NMASTERS'(1) << grant) : stb;
    assign base = ack ? grant : last_grant;
`ifdef FML_ARB_PRIO_EN
    assign pick = req[0] ? '0 : rr_pick(req, base);
`else
    assign pick = rr_pick(req, base);
`endif
    // Arbitrate when idle, after an eack, or when the granted master withdrew.
    assign rearb = !in_grant || ack || !stb[grant];
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= midx_t'(FML_NMASTERS - 1);
        end else begin
            if (ack) last_grant <= grant;
            if (rearb) begin
                state <= |req ? GRANT : IDLE;
                if (|req) grant <= pick;
            end
        end
    end
    assign s_stb = in_grant & stb[grant];
    assign s_we  = in_grant & we[grant];
    assign s_adr = in_grant ? adr[grant] : '0;
    assign {m3_eack, m2_eack, m1_eack, m0_eack} = ack ? FML_NMASTERS'(1) << grant : '0;
    assign m0_do = s_do;
    assign m1_do = s_do;
    assign m2_do = s_do;
    assign m3_do = s_do;
    fml_arb_wdata u_wdata (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (ack & s_we),
        .owner   (grant),
        .di      (di),
        .sel     (sel),
        .s_di    (s_di),
        .s_sel   (s_sel)
    );
endmodule

// File: tb/tb_fml_arb.sv
// tb_fml_arb: randomized and directed self-checking bench for fml_arb against a transaction-level model
module tb_fml_arb;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic [25:0] adr [4];
    logic [7:0] sel [4];
    logic [63:0] di [4];
    logic [3:0] stb = '0;
    logic [3:0] we = '0;
    logic s_eack = 1'b0;
    logic [63:0] s_do = '0;
    logic m0_eack, m1_eack, m2_eack, m3_eack;
    logic [63:0] m0_do, m1_do, m2_do, m3_do;
    logic [25:0] s_adr;
    logic s_stb, s_we;
    logic [7:0] s_sel;
    logic [63:0] s_di;
    int n_chk = 0;
    int n_fail = 0;
    int cur = -1;
    int last = 3;
    int wq[$];

    always #5 sys_clk = ~sys_clk;

    fml_arb dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_adr(adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_eack(m0_eack), .m0_sel(sel[0]), .m0_di(di[0]), .m0_do(m0_do),
        .m1_adr(adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_eack(m1_eack), .m1_sel(sel[1]), .m1_di(di[1]), .m1_do(m1_do),
        .m2_adr(adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_eack(m2_eack), .m2_sel(sel[2]), .m2_di(di[2]), .m2_do(m2_do),
        .m3_adr(adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_eack(m3_eack), .m3_sel(sel[3]), .m3_di(di[3]), .m3_do(m3_do),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_eack(s_eack), .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
    );

    logic [3:0] eack;
    logic [103:0] act;
    assign eack = {m3_eack, m2_eack, m1_eack, m0_eack};
    assign act = {s_stb, s_we, s_adr, s_sel, s_di, eack};

    // Model: cur = granted master (-1 idle), last = last acknowledged master,
    // wq = owners of the write beats still to be forwarded, one entry per cycle.
    function automatic int m_pick(logic [3:0] r, int from);
`ifdef FML_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= 4; k++) if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    function automatic logic [103:0] exp_vec();
        logic [3:0] ea = '0;
        logic st = 1'b0, w = 1'b0;
        logic [25:0] a = '0;
        logic [7:0] se = '0;
        logic [63:0] d = '0;
        if (cur >= 0) begin
            st = stb[cur];
            w = we[cur];
            a = adr[cur];
            ea[cur] = s_eack;
        end
        if (wq.size() != 0) begin
            se = sel[wq[0]];
            d = di[wq[0]];
        end
        return {st, w, a, se, d, ea};
    endfunction

    task automatic m_edge();
        logic [3:0] r;
        if (sys_rst) begin
            cur = -1;
            last = 3;
            wq.delete();
            return;
        end
        if (wq.size() != 0) void'(wq.pop_front());
        if (cur >= 0 && s_eack) begin
            if (we[cur]) wq = '{cur, cur, cur, cur};
            last = cur;
            r = stb;
            r[cur] = 1'b0;
            cur = (r != 0) ? m_pick(r, last) : -1;
        end else if (cur < 0 || !stb[cur]) begin
            cur = (stb != 0) ? m_pick(stb, last) : -1;
        end
    endtask

    task automatic adv();
        @(posedge sys_clk);
        m_edge();
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        stb = '0;
        we = '0;
        s_eack = 1'b0;
        adv();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        stb = 4'hF;
        we = 4'hF;
        s_eack = 1'b0;
        adv();
        adv();
        @(negedge sys_clk);
        n_chk++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", act); end
        n_chk++;
        if (act !== exp_vec()) begin n_fail++; $display("FAIL reset_model: got %h want %h", act, exp_vec()); end
        sys_rst = 1'b0;
        stb = '0;
        we = '0;
        adv();
    endtask

    task automatic test_single_read();
        int acks = 0;
        adr[1] = 26'h100;
        for (int c = 0; c < 7; c++) begin
            stb = (c < 4) ? 4'b0010 : 4'b0000;
            we = '0;
            s_eack = (c == 3);
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL single_read c%0d: got %h want %h", c, act, exp_vec()); end
            if (c == 0) begin
                n_chk++;
                if (s_stb !== 1'b0) begin n_fail++; $display("FAIL grant_latency: s_stb got %b want 0", s_stb); end
            end
            if (c == 1) begin
                n_chk++;
                if ({s_stb, s_adr} !== {1'b1, 26'h100}) begin n_fail++; $display("FAIL read_addr: got %b/%h want 1/100", s_stb, s_adr); end
            end
            if (c == 4) begin
                n_chk++;
                if (s_stb !== 1'b0) begin n_fail++; $display("FAIL read_idle: s_stb got %b want 0", s_stb); end
            end
            acks += int'(m1_eack);
            adv();
        end
        s_eack = 1'b0;
        n_chk++;
        if (acks != 1) begin n_fail++; $display("FAIL read_ack_count: got %0d want 1", acks); end
    endtask

    task automatic test_round_robin();
        int got[$];
        int want[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int c = 0; c < 22; c++) begin
            stb = (c < 21) ? 4'hF : 4'h0;
            we = '0;
            s_eack = (c >= 4 && c % 4 == 0);
            for (int n = 0; n < 4; n++) adr[n] = 26'(n * 16 + c);
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL rr c%0d: got %h want %h", c, act, exp_vec()); end
            for (int n = 0; n < 4; n++) if (eack[n]) got.push_back(n);
            adv();
        end
        stb = '0;
        s_eack = 1'b0;
        n_chk++;
        if (got.size() != 5) begin n_fail++; $display("FAIL rr_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] != want[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], want[i]); end
        end
    endtask

    task automatic test_write_burst();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            stb = (c < 3) ? 4'b0100 : 4'b0000;
            we = 4'b0100;
            s_eack = (c == 2);
            di[2] = (c >= 3 && c <= 6) ? 64'hA + 64'(c - 3) : 64'hDEAD_BEEF;
            sel[2] = (c >= 3 && c <= 6) ? 8'hFF : 8'h5A;
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL wr c%0d: got %h want %h", c, act, exp_vec()); end
            if (c >= 3 && c <= 6) begin
                n_chk++;
                if ({s_sel, s_di} !== {8'hFF, 64'hA + 64'(c - 3)}) begin n_fail++; $display("FAIL wr_beat%0d: got %h/%h", c - 3, s_sel, s_di); end
            end
            if (c == 7) begin
                n_chk++;
                if ({s_sel, s_di} !== '0) begin n_fail++; $display("FAIL wr_end: got %h/%h want 0/0", s_sel, s_di); end
            end
            adv();
        end
        s_eack = 1'b0;
        we = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        sel[0] = 8'hFF;
        sel[3] = 8'hFF;
        for (int c = 0; c < 12; c++) begin
            stb = {c < 6, 2'b00, c < 2};
            we = 4'b1001;
            s_eack = (c == 1 || c == 5);
            di[0] = 64'(c) + 64'hFE;
            di[3] = 64'(c) + 64'h2FA;
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL b2b c%0d: got %h want %h", c, act, exp_vec()); end
            if (c >= 2 && c <= 5) begin
                n_chk++;
                if (s_di !== 64'h100 + 64'(c - 2)) begin n_fail++; $display("FAIL b2b_m0 c%0d: got %h want %h", c, s_di, 64'h100 + 64'(c - 2)); end
            end
            if (c >= 6 && c <= 9) begin
                n_chk++;
                if (s_di !== 64'h300 + 64'(c - 6)) begin n_fail++; $display("FAIL b2b_m3 c%0d: got %h want %h", c, s_di, 64'h300 + 64'(c - 6)); end
            end
            if (c == 10) begin
                n_chk++;
                if (s_sel !== 8'h00) begin n_fail++; $display("FAIL b2b_end: s_sel got %h want 00", s_sel); end
            end
            adv();
        end
        s_eack = 1'b0;
        we = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        sel[1] = 8'hFF;
        for (int c = 0; c < 7; c++) begin
            stb = (c < 2) ? 4'b0010 : (c < 4) ? 4'b0100 : (c < 6) ? 4'b0111 : 4'b0000;
            we = (c < 2) ? 4'b0010 : 4'b0000;
            s_eack = (c == 1 || c == 5);
            sys_rst = (c == 3);
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL rst_mid c%0d: got %h want %h", c, act, exp_vec()); end
            if (c == 3) begin
                n_chk++;
                if ({s_stb, s_sel} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL rst_mid_pre: got %b/%h want 1/ff", s_stb, s_sel); end
            end
            if (c == 4) begin
                n_chk++;
                if ({s_stb, s_sel} !== 9'h0) begin n_fail++; $display("FAIL rst_mid_abort: got %b/%h want 0/00", s_stb, s_sel); end
            end
            if (c == 5) begin
                n_chk++;
                if (eack !== 4'b0001) begin n_fail++; $display("FAIL rst_next_grant: eack got %b want 0001", eack); end
            end
            adv();
        end
        s_eack = 1'b0;
        sys_rst = 1'b0;
    endtask

    task automatic test_priority();
        logic [3:0] want;
`ifdef FML_ARB_PRIO_EN
        want = 4'b0001;
`else
        want = 4'b0010;
`endif
        do_reset();
        for (int c = 0; c < 6; c++) begin
            stb = (c < 2) ? 4'b0001 : (c == 2 || c == 5) ? 4'b0000 : 4'b0011;
            we = '0;
            s_eack = (c == 1 || c == 4);
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL prio c%0d: got %h want %h", c, act, exp_vec()); end
            if (c == 4) begin
                n_chk++;
                if (eack !== want) begin n_fail++; $display("FAIL prio_first: eack got %b want %b", eack, want); end
            end
            adv();
        end
        s_eack = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(3) == 0) stb[n] = ~stb[n];
                we[n] = 1'($urandom_range(1));
                adr[n] = 26'($urandom);
                sel[n] = 8'($urandom);
                di[n] = {$urandom, $urandom};
            end
            s_do = {$urandom, $urandom};
            sys_rst = ($urandom_range(99) == 0);
            s_eack = 1'b0;
            if (cur >= 0) s_eack = ($urandom_range(2) == 0) && !(we[cur] && wq.size() > 1);
            @(negedge sys_clk);
            n_chk++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL rand c%0d: got %h want %h", c, act, exp_vec()); end
            n_chk++;
            if ({m0_do, m1_do, m2_do, m3_do} !== {4{s_do}}) begin n_fail++; $display("FAIL rand_do c%0d: got %h want %h", c, m0_do, s_do); end
            adv();
        end
        sys_rst = 1'b0;
        s_eack = 1'b0;
        stb = '0;
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            adr[n] = '0;
            sel[n] = '0;
            di[n] = '0;
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_burst();
        test_back_to_back();
        test_reset_mid_burst();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
